ntt_fetch: RTL and testbench

Operand-fetch stage that sits directly downstream of the address-generation stage (the `AD` outputs) and directly upstream of the butterfly unit. For each valid address beat it reads two coefficients from the external coefficient RAM and one twiddle from the zeta ROM. It then delivers them to the butterfly with the addresses and flags aligned, ready for write-back. It also conditions the twiddle for INTT and performs per-run integrity checks: butterfly count and mode stability.

---
 rtl/ntt_fetch_if.sv | 28 ++
 rtl/ntt_fetch.sv | 189 ++++++++++++++++++
 tb/tb_ntt_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_fetch_if.sv
// ntt_fetch_if: read bus between the NTT operand-fetch stage and its memories.
//   ram_rd_en, ram_addr_a/b : coefficient RAM read request (fetch -> RAM)
//   ram_q_a/b               : coefficient RAM read data    (RAM -> fetch)
//   zeta_rd_en, zeta_addr   : twiddle ROM read request     (fetch -> ROM)
//   zeta_q                  : twiddle ROM read data        (ROM -> fetch)
// The fetch stage uses the master modport; the memory side uses slave.
interface ntt_fetch_if #(
    parameter int W = 12
);
    logic         ram_rd_en;
    logic [7:0]   ram_addr_a;
    logic [7:0]   ram_addr_b;
    logic [W-1:0] ram_q_a;
    logic [W-1:0] ram_q_b;
    logic         zeta_rd_en;
    logic [6:0]   zeta_addr;
    logic [W-1:0] zeta_q;

    modport master (
        output ram_rd_en, ram_addr_a, ram_addr_b, zeta_rd_en, zeta_addr,
        input  ram_q_a, ram_q_b, zeta_q
    );

    modport slave (
        input  ram_rd_en, ram_addr_a, ram_addr_b, zeta_rd_en, zeta_addr,
        output ram_q_a, ram_q_b, zeta_q
    );
endinterface

// File: rtl/ntt_fetch.sv
// ntt_fetch: operand-fetch stage between NTT address generation and the
// butterfly. Issues coefficient/twiddle reads for each address beat, aligns
// the beat's addresses and flags with the returned data, conditions the
// twiddle for INTT and tracks per-run butterfly count and mode stability.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_a .. i_done     : address beat from the address generator
//   mem (master)      : coefficient RAM / twiddle ROM read bus
//   o_f .. o_done     : operand beat to the butterfly (o_f/o_last/o_done pulse)
//   o_busy            : run in progress
//   o_bf_cnt          : butterflies delivered in the current run (saturating)
//   o_cnt_err         : sticky, done beat count differed from EXP_BF
//   o_sel_err         : sticky, a beat's mode differed from the run mode
//
// Run FSM:
//   state    | meaning
//   ST_IDLE  | no run open; next delivered beat starts a run
//   ST_RUN   | run open; counting beats until the done beat
module ntt_fetch #(
    parameter int W      = 12,
    parameter int Q      = 3329,
    parameter int RD_LAT = 1,
    parameter int EXP_BF = 896
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_a,
    input  logic [7:0]     i_addr_up,
    input  logic [7:0]     i_addr_dn,
    input  logic [6:0]     i_addr_zeta,
    input  logic           i_sel,
    input  logic           i_last,
    input  logic           i_done,
    ntt_fetch_if.master    mem,
    output logic           o_f,
    output logic [W-1:0]   o_u,
    output logic [W-1:0]   o_v,
    output logic [W-1:0]   o_zeta,
    output logic [7:0]     o_addr_up,
    output logic [7:0]     o_addr_dn,
    output logic           o_sel,
    output logic           o_last,
    output logic           o_done,
    output logic           o_busy,
    output logic [9:0]     o_bf_cnt,
    output logic           o_cnt_err,
    output logic           o_sel_err
);

    localparam logic [W-1:0] LP_Q = W'(Q);

    typedef struct packed {
        logic       a;
        logic [7:0] up;
        logic [7:0] dn;
        logic       sel;
        logic       last;
        logic       done;
    } sb_t;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    sb_t          w_sb_in;
    sb_t          w_sb;
    sb_t          r_dl [RD_LAT];
    logic         w_v;
    logic [W-1:0] w_zeta;

    state_t       r_state, w_state_nxt;
    logic         r_mode, w_mode_nxt;
    logic [9:0]   r_bf_cnt, w_cnt_nxt;
    logic         r_cnt_err, w_cnt_err_nxt;
    logic         r_sel_err, w_sel_err_nxt;
    logic         r_f;

    // Reads are issued straight from the address beat, even during reset.
    assign mem.ram_rd_en  = i_a;
    assign mem.zeta_rd_en = i_a;
    assign mem.ram_addr_a = i_addr_up;
    assign mem.ram_addr_b = i_addr_dn;
    assign mem.zeta_addr  = i_addr_zeta;

    always_comb begin
        w_sb_in = '{a: i_a, up: i_addr_up, dn: i_addr_dn,
                    sel: i_sel, last: i_last, done: i_done};
    end

    // Sideband line matches the memory read latency so the tail entry
    // describes the data currently on ram_q_*/zeta_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= w_sb_in;
            for (int i = 1; i < RD_LAT; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign w_sb = r_dl[RD_LAT-1];
    assign w_v  = w_sb.a;

    // INTT uses the negated twiddle; zero stays zero rather than becoming Q.
    always_comb begin
        w_zeta = mem.zeta_q;
        if (w_sb.sel) begin
            w_zeta = (mem.zeta_q == '0) ? '0 : LP_Q - mem.zeta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f       <= 1'b0;
            o_last    <= 1'b0;
            o_done    <= 1'b0;
            o_u       <= '0;
            o_v       <= '0;
            o_zeta    <= '0;
            o_addr_up <= '0;
            o_addr_dn <= '0;
            o_sel     <= 1'b0;
        end else begin
            r_f    <= w_v;
            o_last <= w_v & w_sb.last;
            o_done <= w_v & w_sb.done;
            if (w_v) begin
                o_u       <= mem.ram_q_a;
                o_v       <= mem.ram_q_b;
                o_zeta    <= w_zeta;
                o_addr_up <= w_sb.up;
                o_addr_dn <= w_sb.dn;
                o_sel     <= w_sb.sel;
            end
        end
    end

    // Run bookkeeping advances on the same edge that loads the output
    // register, so the count and error flags already include the beat
    // that is visible on o_f.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_cnt_nxt     = r_bf_cnt;
        w_cnt_err_nxt = r_cnt_err;
        w_sel_err_nxt = r_sel_err;
        if (w_v) begin
            if (r_state == ST_IDLE) begin
                w_mode_nxt    = w_sb.sel;
                w_cnt_nxt     = 10'd1;
                w_cnt_err_nxt = 1'b0;
                w_sel_err_nxt = 1'b0;
            end else begin
                w_cnt_nxt = (r_bf_cnt == '1) ? r_bf_cnt : r_bf_cnt + 10'd1;
                if (w_sb.sel != r_mode) w_sel_err_nxt = 1'b1;
            end
            if (w_sb.done) begin
                w_state_nxt = ST_IDLE;
                if (int'(w_cnt_nxt) != EXP_BF) w_cnt_err_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_bf_cnt  <= '0;
            r_cnt_err <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_bf_cnt  <= w_cnt_nxt;
            r_cnt_err <= w_cnt_err_nxt;
            r_sel_err <= w_sel_err_nxt;
        end
    end

    // The delivered-beat pulse keeps busy high on a done beat even though
    // the state has already returned to idle.
    assign o_f       = r_f;
    assign o_busy    = (r_state == ST_RUN) | r_f;
    assign o_bf_cnt  = r_bf_cnt;
    assign o_cnt_err = r_cnt_err;
    assign o_sel_err = r_sel_err;

endmodule

// File: tb/tb_ntt_fetch.sv
// tb_ntt_fetch: drives two ntt_fetch instances (RD_LAT 1 and 2) with the
// same random beat stream, each backed by its own latency-matched memory
// model, and compares every output on every cycle against a beat-level
// reference model, plus hand-computed literal checks.
module tb_ntt_fetch;
    localparam int W      = 12;
    localparam int Q      = 3329;
    localparam int EXP_BF = 896;
    localparam int HN     = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic       i_a, i_sel, i_last, i_done;
    logic [7:0] i_addr_up, i_addr_dn;
    logic [6:0] i_addr_zeta;

    logic [1:0]          o_f, o_sel, o_last, o_done, o_busy, o_cnt_err, o_sel_err;
    logic [1:0][W-1:0]   o_u, o_v, o_zeta;
    logic [1:0][7:0]     o_addr_up, o_addr_dn;
    logic [1:0][9:0]     o_bf_cnt;
    logic [1:0]          rd_en_w, zrd_en_w;
    logic [1:0][7:0]     ra_w, rb_w;
    logic [1:0][6:0]     za_w;

    logic [W-1:0] ram [256];
    logic [W-1:0] rom [128];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int last_rst = -1;
    int cur = 0;
    bit chk_en = 1'b0;

    logic       h_a [HN];
    logic [7:0] h_up [HN];
    logic [7:0] h_dn [HN];
    logic [6:0] h_z [HN];
    logic       h_sel [HN];
    logic       h_last [HN];
    logic       h_done [HN];

    logic [W-1:0] m_u [2];
    logic [W-1:0] m_v [2];
    logic [W-1:0] m_z [2];
    logic [7:0]   m_up [2];
    logic [7:0]   m_dn [2];
    logic         m_sel [2];
    logic         m_act [2];
    logic         m_mode [2];
    logic         m_ce [2];
    logic         m_se [2];
    int           m_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ntt_fetch_if #(.W(W)) mem_if ();
        logic [W-1:0] pa [0:k];
        logic [W-1:0] pb [0:k];
        logic [W-1:0] pz [0:k];

        always @(posedge clk) begin
            if (mem_if.ram_rd_en) begin
                pa[0] <= ram[mem_if.ram_addr_a];
                pb[0] <= ram[mem_if.ram_addr_b];
            end
            if (mem_if.zeta_rd_en) pz[0] <= rom[mem_if.zeta_addr];
            for (int i = 1; i <= k; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
                pz[i] <= pz[i-1];
            end
        end
        assign mem_if.ram_q_a = pa[k];
        assign mem_if.ram_q_b = pb[k];
        assign mem_if.zeta_q  = pz[k];
        assign rd_en_w[k]  = mem_if.ram_rd_en;
        assign zrd_en_w[k] = mem_if.zeta_rd_en;
        assign ra_w[k]     = mem_if.ram_addr_a;
        assign rb_w[k]     = mem_if.ram_addr_b;
        assign za_w[k]     = mem_if.zeta_addr;

        ntt_fetch #(.W(W), .Q(Q), .RD_LAT(k + 1), .EXP_BF(EXP_BF)) u_dut (
            .clk(clk), .rst(rst),
            .i_a(i_a), .i_addr_up(i_addr_up), .i_addr_dn(i_addr_dn),
            .i_addr_zeta(i_addr_zeta), .i_sel(i_sel), .i_last(i_last), .i_done(i_done),
            .mem(mem_if),
            .o_f(o_f[k]), .o_u(o_u[k]), .o_v(o_v[k]), .o_zeta(o_zeta[k]),
            .o_addr_up(o_addr_up[k]), .o_addr_dn(o_addr_dn[k]), .o_sel(o_sel[k]),
            .o_last(o_last[k]), .o_done(o_done[k]), .o_busy(o_busy[k]),
            .o_bf_cnt(o_bf_cnt[k]), .o_cnt_err(o_cnt_err[k]), .o_sel_err(o_sel_err[k])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, want %0d", nm, k, cyc, act, exp);
        end
    endtask

    // Beat-level reference: a beat entered in cycle j is delivered in cycle
    // j+L+1 unless a reset was seen at or after j.
    task automatic model_cmp(input int k);
        int L, j;
        logic f, lst, dn, bsy;
        logic [W-1:0] rz;
        L = k + 1; f = 0; lst = 0; dn = 0;
        chk("ram_rd_en", k, 32'(rd_en_w[k]), 32'(i_a));
        chk("zeta_rd_en", k, 32'(zrd_en_w[k]), 32'(i_a));
        chk("ram_addr_a", k, 32'(ra_w[k]), 32'(i_addr_up));
        chk("ram_addr_b", k, 32'(rb_w[k]), 32'(i_addr_dn));
        chk("zeta_addr", k, 32'(za_w[k]), 32'(i_addr_zeta));
        if (rst) begin
            m_u[k] = '0; m_v[k] = '0; m_z[k] = '0; m_up[k] = '0; m_dn[k] = '0;
            m_sel[k] = 0; m_act[k] = 0; m_mode[k] = 0; m_ce[k] = 0; m_se[k] = 0;
            m_cnt[k] = 0;
        end else begin
            j = cyc - L - 1;
            if (j >= 0 && j > last_rst && h_a[j] === 1'b1) begin
                f = 1; lst = h_last[j]; dn = h_done[j];
                rz = rom[h_z[j]];
                m_u[k] = ram[h_up[j]];
                m_v[k] = ram[h_dn[j]];
                m_z[k] = !h_sel[j] ? rz : (rz == 0 ? '0 : W'(Q - int'(rz)));
                m_up[k] = h_up[j]; m_dn[k] = h_dn[j]; m_sel[k] = h_sel[j];
                if (!m_act[k]) begin
                    m_act[k] = 1; m_mode[k] = h_sel[j]; m_cnt[k] = 1;
                    m_ce[k] = 0; m_se[k] = 0;
                end else begin
                    if (m_cnt[k] < 1023) m_cnt[k]++;
                    if (h_sel[j] != m_mode[k]) m_se[k] = 1;
                end
                if (dn) begin
                    if (m_cnt[k] != EXP_BF) m_ce[k] = 1;
                    m_act[k] = 0;
                end
            end
        end
        bsy = f | m_act[k];
        chk("o_f", k, 32'(o_f[k]), 32'(f));
        chk("o_last", k, 32'(o_last[k]), 32'(lst));
        chk("o_done", k, 32'(o_done[k]), 32'(dn));
        chk("o_u", k, 32'(o_u[k]), 32'(m_u[k]));
        chk("o_v", k, 32'(o_v[k]), 32'(m_v[k]));
        chk("o_zeta", k, 32'(o_zeta[k]), 32'(m_z[k]));
        chk("o_addr_up", k, 32'(o_addr_up[k]), 32'(m_up[k]));
        chk("o_addr_dn", k, 32'(o_addr_dn[k]), 32'(m_dn[k]));
        chk("o_sel", k, 32'(o_sel[k]), 32'(m_sel[k]));
        chk("o_busy", k, 32'(o_busy[k]), 32'(bsy));
        chk("o_bf_cnt", k, 32'(o_bf_cnt[k]), 32'(m_cnt[k]));
        chk("o_cnt_err", k, 32'(o_cnt_err[k]), 32'(m_ce[k]));
        chk("o_sel_err", k, 32'(o_sel_err[k]), 32'(m_se[k]));
    endtask

    always @(negedge clk) begin
        if (cyc >= HN) begin
            $display("FAIL history_overflow cyc %0d: got %0d, want below %0d", cyc, cyc, HN);
            $fatal(1, "history overflow");
        end
        h_a[cyc] = i_a; h_up[cyc] = i_addr_up; h_dn[cyc] = i_addr_dn;
        h_z[cyc] = i_addr_zeta; h_sel[cyc] = i_sel; h_last[cyc] = i_last;
        h_done[cyc] = i_done;
        if (rst) last_rst = cyc;
        if (chk_en) for (int k = 0; k < 2; k++) model_cmp(k);
    end

    task automatic beat_fix(input logic [7:0] up, input logic [7:0] dn, input logic [6:0] z,
                            input logic s, input logic lst, input logic d);
        @(posedge clk); #1;
        i_a = 1'b1; i_addr_up = up; i_addr_dn = dn; i_addr_zeta = z;
        i_sel = s; i_last = lst; i_done = d;
        cur = cyc;
    endtask

    task automatic beat(input logic s, input logic lst, input logic d);
        beat_fix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 7'($urandom_range(0, 127)), s, lst, d);
    endtask

    // Idle cycles toggle every other input, including a stray done.
    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
            i_a = 1'b0;
            i_addr_up = 8'($urandom_range(0, 255)); i_addr_dn = 8'($urandom_range(0, 255));
            i_addr_zeta = 7'($urandom_range(0, 127));
            i_sel = 1'($urandom_range(0, 1)); i_last = 1'($urandom_range(0, 1));
            i_done = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic at_neg(input int m);
        while (cyc < m) idle(1);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic s0, input int flip_at, input bit gaps,
                       input bit fin, output int last_i, output int flip_i);
        logic s;
        s = s0; flip_i = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            if (i == flip_at) s = ~s0;
            beat(s, (n - i) <= 128, fin && (i == n - 1));
            if (i == flip_at) flip_i = cur;
        end
        last_i = cur;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc %0d: got timeout, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, li, fi;
        i_a = 0; i_addr_up = 0; i_addr_dn = 0; i_addr_zeta = 0;
        i_sel = 0; i_last = 0; i_done = 0;
        for (int i = 0; i < 256; i++) ram[i] = W'($urandom_range(0, 4095));
        for (int i = 0; i < 128; i++) rom[i] = W'($urandom_range(0, Q - 1));
        ram[5] = 12'd100; ram[133] = 12'd2000; rom[1] = 12'd17; rom[3] = 12'd0;
        #2 rst = 1'b1; chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single NTT beat, closed as a one-beat run
        beat_fix(8'd5, 8'd133, 7'd1, 1'b0, 1'b0, 1'b1); n0 = cur;
        at_neg(n0 + 2);
        chk("single_f", 0, 32'(o_f[0]), 1);
        chk("single_u", 0, 32'(o_u[0]), 100);
        chk("single_v", 0, 32'(o_v[0]), 2000);
        chk("single_zeta", 0, 32'(o_zeta[0]), 17);
        chk("single_up", 0, 32'(o_addr_up[0]), 5);
        chk("single_dn", 0, 32'(o_addr_dn[0]), 133);
        chk("single_cnt", 0, 32'(o_bf_cnt[0]), 1);
        chk("single_cnt_err", 0, 32'(o_cnt_err[0]), 1);
        chk("single_lat2_early", 1, 32'(o_f[1]), 0);
        at_neg(n0 + 3);
        chk("single_lat2_f", 1, 32'(o_f[1]), 1);
        chk("single_lat2_u", 1, 32'(o_u[1]), 100);
        chk("single_busy_drop", 0, 32'(o_busy[0]), 0);

        // INTT twiddles, back-to-back one-beat runs
        beat_fix(8'd5, 8'd133, 7'd1, 1'b1, 1'b0, 1'b1); n0 = cur;
        beat_fix(8'd5, 8'd133, 7'd3, 1'b1, 1'b0, 1'b1); li = cur;
        at_neg(n0 + 2);
        chk("intt_zeta", 0, 32'(o_zeta[0]), 3312);
        chk("intt_sel", 0, 32'(o_sel[0]), 1);
        at_neg(li + 2);
        chk("intt_zero_f", 0, 32'(o_f[0]), 1);
        chk("intt_zero_zeta", 0, 32'(o_zeta[0]), 0);
        chk("intt_new_run_cnt", 0, 32'(o_bf_cnt[0]), 1);
        at_neg(li + 3);
        chk("intt_zero_zeta", 1, 32'(o_zeta[1]), 0);

        // full NTT run
        run(896, 1'b0, -1, 1'b0, 1'b1, li, fi);
        at_neg(li + 2);
        chk("full_done", 0, 32'(o_done[0]), 1);
        chk("full_last", 0, 32'(o_last[0]), 1);
        chk("full_cnt", 0, 32'(o_bf_cnt[0]), 896);
        chk("full_cnt_err", 0, 32'(o_cnt_err[0]), 0);
        chk("full_busy", 0, 32'(o_busy[0]), 1);
        at_neg(li + 3);
        chk("full_busy_drop", 0, 32'(o_busy[0]), 0);
        chk("full_done_pulse", 0, 32'(o_done[0]), 0);
        chk("full_cnt", 1, 32'(o_bf_cnt[1]), 896);

        // short run, error sticky while idle, cleared by a good run
        run(500, 1'b0, -1, 1'b0, 1'b1, li, fi);
        at_neg(li + 3);
        chk("short_cnt_err", 0, 32'(o_cnt_err[0]), 1);
        chk("short_cnt", 0, 32'(o_bf_cnt[0]), 500);
        idle(20);
        at_neg(cyc);
        chk("short_err_sticky", 0, 32'(o_cnt_err[0]), 1);
        chk("short_idle_busy", 0, 32'(o_busy[0]), 0);
        run(896, 1'b0, -1, 1'b0, 1'b1, li, fi);
        at_neg(li + 3);
        chk("short_err_cleared", 0, 32'(o_cnt_err[0]), 0);

        // mode change at beat 300
        run(896, 1'b0, 299, 1'b0, 1'b1, li, fi);
        at_neg(li + 3);
        chk("mode_sel_err", 0, 32'(o_sel_err[0]), 1);
        chk("mode_cnt_err", 0, 32'(o_cnt_err[0]), 0);
        chk("mode_sel_err", 1, 32'(o_sel_err[1]), 1);

        // INTT run with gaps; first beat clears the old sel error
        run(896, 1'b1, -1, 1'b1, 1'b1, li, fi);
        at_neg(li + 3);
        chk("gap_sel_err", 0, 32'(o_sel_err[0]), 0);
        chk("gap_cnt_err", 0, 32'(o_cnt_err[0]), 0);
        chk("gap_cnt", 1, 32'(o_bf_cnt[1]), 896);

        // reset mid-run with beats in flight
        run(200, 1'b0, -1, 1'b0, 1'b0, li, fi);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_f", 0, 32'(o_f[0]), 0);
        chk("rst_f", 1, 32'(o_f[1]), 0);
        chk("rst_u", 1, 32'(o_u[1]), 0);
        chk("rst_cnt", 0, 32'(o_bf_cnt[0]), 0);
        chk("rst_busy", 1, 32'(o_busy[1]), 0);
        @(posedge clk); #1;
        rst = 1'b0; i_a = 1'b0;
        beat_fix(8'd5, 8'd133, 7'd1, 1'b0, 1'b0, 1'b0); n0 = cur;
        at_neg(n0 + 2);
        chk("restart_lat2_early", 1, 32'(o_f[1]), 0);
        at_neg(n0 + 3);
        chk("restart_lat2_f", 1, 32'(o_f[1]), 1);
        chk("restart_lat2_cnt", 1, 32'(o_bf_cnt[1]), 1);
        chk("restart_lat2_u", 1, 32'(o_u[1]), 100);
        run(895, 1'b0, -1, 1'b0, 1'b1, li, fi);
        at_neg(li + 3);
        chk("restart_cnt", 1, 32'(o_bf_cnt[1]), 896);
        chk("restart_cnt_err", 1, 32'(o_cnt_err[1]), 0);

        // random short runs
        repeat (12) begin
            run(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 60)), 1'b1, 1'b1, li, fi);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        at_neg(cyc + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
